// File: rtl/bp_lce_wormhole_serializer.sv
// ============================================================================
// Module   : bp_lce_wormhole_serializer
// Brief    : Splits one LCE packet into len+1 wormhole flits, lowest slice
//            first. Out-of-range len fields are clamped to the largest length
//            the packet can hold, rewritten in the header and flagged.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_lce_wormhole_serializer #(
  parameter int flit_width_p = 32,
  parameter int pkt_width_p  = 96,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [pkt_width_p-1:0]  pkt_i,
  input  logic                    pkt_v_i,
  output logic                    pkt_ready_and_o,
  output logic [flit_width_p-1:0] link_data_o,
  output logic                    link_v_o,
  input  logic                    link_ready_and_i,
  output logic                    len_err_o
);

  localparam int max_len_lp    = (pkt_width_p + flit_width_p - 1) / flit_width_p - 1;
  localparam int cnt_width_lp  = (max_len_lp > 0) ? $clog2(max_len_lp + 1) : 1;
  // Buffer rounded up to whole flits so the last slice reads zeros past the packet
  localparam int padded_width_lp = (max_len_lp + 1) * flit_width_p;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_send = 1'b1
  } state_e;

  state_e                     state_r, state_n;
  logic [padded_width_lp-1:0] buffer_r;
  logic [cnt_width_lp-1:0]    cnt_r;
  logic [cnt_width_lp-1:0]    len_r;
  logic                       len_err_r;

  logic                       accept;
  logic                       link_hs;
  logic                       last_flit;
  logic [len_width_p-1:0]     len_in;
  logic                       clamp;
  logic [pkt_width_p-1:0]     pkt_fixed;

  // Handshake and header decode
  always_comb begin
    len_in    = pkt_i[cord_width_p +: len_width_p];
    clamp     = (len_in > len_width_p'(max_len_lp));
    pkt_fixed = pkt_i;
    if (clamp) begin
      pkt_fixed[cord_width_p +: len_width_p] = len_width_p'(max_len_lp);
    end
    accept    = pkt_v_i & pkt_ready_and_o;
    link_hs   = link_v_o & link_ready_and_i;
    last_flit = (cnt_r == len_r);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and handshake outputs; reset masks both sides of the link
  always_comb begin
    state_n         = state_r;
    pkt_ready_and_o = 1'b0;
    link_v_o        = 1'b0;
    case (state_r)
      e_idle: begin
        pkt_ready_and_o = ~reset_i;
        if (accept) begin
          state_n = e_send;
        end
      end
      e_send: begin
        link_v_o = ~reset_i;
        if (link_hs && last_flit) begin
          state_n = e_idle;
        end
      end
      default: state_n = e_idle;
    endcase
  end

  // Packet buffer, length and flit counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buffer_r  <= '0;
      cnt_r     <= '0;
      len_r     <= '0;
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= accept & clamp;
      if (accept) begin
        buffer_r <= padded_width_lp'(pkt_fixed);
        cnt_r    <= '0;
        len_r    <= clamp ? cnt_width_lp'(max_len_lp) : cnt_width_lp'(len_in);
      end else if (link_hs && !last_flit) begin
        cnt_r <= cnt_r + cnt_width_lp'(1);
      end
    end
  end

  // Flit select comes only from registered state
  always_comb begin
    link_data_o = reset_i ? '0 : buffer_r[cnt_r * flit_width_p +: flit_width_p];
    len_err_o   = len_err_r & ~reset_i;
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_lce_wormhole_serializer.sv
// ============================================================================
// Module   : tb_bp_lce_wormhole_serializer
// Brief    : Directed and random stimulus against a flit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_lce_wormhole_serializer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [95:0] pkt_i = '0;
  logic        pkt_v_i = 1'b0;
  logic        pkt_ready_and_o;
  logic [31:0] link_data_o;
  logic        link_v_o;
  logic        link_ready_and_i = 1'b0;
  logic        len_err_o;

  bp_lce_wormhole_serializer #(
    .flit_width_p(32),
    .pkt_width_p (96),
    .cord_width_p(8),
    .len_width_p (4)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .pkt_i           (pkt_i),
    .pkt_v_i         (pkt_v_i),
    .pkt_ready_and_o (pkt_ready_and_o),
    .link_data_o     (link_data_o),
    .link_v_o        (link_v_o),
    .link_ready_and_i(link_ready_and_i),
    .len_err_o       (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: flits still owed for the packet in flight
  logic [31:0] expq[$];
  bit          exp_err = 1'b0;
  int          total = 0;
  int          bad = 0;

  localparam logic [95:0] P3 = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_2205};
  localparam logic [95:0] P7 = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_2705};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packet rule: len field at [11:8], clamp to 2, then len+1 32-bit slices
  task automatic push_pkt(input logic [95:0] p_in);
    logic [95:0] p;
    int          len;
    p   = p_in;
    len = int'(p[11:8]);
    if (len > 2) begin
      len     = 2;
      p[11:8] = 4'd2;
      exp_err = 1'b1;
    end
    for (int i = 0; i <= len; i++) expq.push_back(p[i*32 +: 32]);
  endtask

  // One clock: drive, check outputs against the model, advance the model
  task automatic tick(input bit rst, input bit pv, input logic [95:0] p, input bit lr);
    bit exp_ready, exp_v, acc, hs;
    reset_i          = rst;
    pkt_v_i          = pv;
    pkt_i            = p;
    link_ready_and_i = lr;
    #1;
    exp_ready = !rst && (expq.size() == 0);
    exp_v     = !rst && (expq.size() != 0);
    check("pkt_ready", 32'(pkt_ready_and_o), 32'(exp_ready));
    check("link_v", 32'(link_v_o), 32'(exp_v));
    check("len_err", 32'(len_err_o), 32'(exp_err && !rst));
    if (exp_v) check("link_data", link_data_o, expq[0]);
    if (rst) check("reset_data", link_data_o, 32'h0);
    acc = pv && exp_ready;
    hs  = exp_v && lr;
    @(posedge clk_i);
    exp_err = 1'b0;
    if (rst) begin
      expq.delete();
    end else begin
      if (hs) void'(expq.pop_front());
      if (acc) push_pkt(p);
    end
    @(negedge clk_i);
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && expq.size() != 0; n++) tick(0, 0, '0, 1);
    tick(0, 0, '0, 1);
  endtask

  initial begin
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);

    // Reset state, including a packet offered during reset
    tick(1, 1, P3, 1);
    tick(0, 0, '0, 1);

    // Single flit
    tick(0, 1, 96'h12, 1);
    drain();

    // Three flits, ready held high
    tick(0, 1, P3, 1);
    drain();

    // Backpressure on flit 1
    tick(0, 1, P3, 1);
    tick(0, 0, '0, 1);
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    tick(0, 0, '0, 0);
    drain();

    // Length clamp
    tick(0, 1, P7, 1);
    check("clamp_len_field", 32'(link_data_o[11:8]), 32'd2);
    drain();

    // Reset after flit 0, then a new packet
    tick(0, 1, P3, 1);
    tick(0, 0, '0, 1);
    tick(1, 0, '0, 1);
    tick(0, 1, {32'h3333_3333, 32'h2222_2222, 32'h1111_0207}, 1);
    drain();

    // Back-to-back single-flit packets with valid held high
    for (int i = 0; i < 6; i++) tick(0, 1, {88'h0, 8'h20 + 8'(i)}, 1);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [95:0] rp;
      rp = {$urandom, $urandom, $urandom};
      tick(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, rp,
           $urandom_range(0, 3) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
